// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int DEF_DIVIDEND_W = 16;
  localparam int DEF_DIVISOR_W  = 8;

  localparam logic [DEF_DIVIDEND_W-1:0] DEF_DIVIDEND_MIN = {1'b1, {(DEF_DIVIDEND_W-1){1'b0}}};
  localparam logic [DEF_DIVISOR_W-1:0]  DEF_DIVISOR_NEG1 = '1;

  // Ceiling log2 with a floor of one bit, so a counter always exists.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, compare, conditionally subtract.
module div_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W:0] rem_in,
  input  logic               bit_in,
  input  logic [DIVISOR_W:0] divisor,
  output logic [DIVISOR_W:0] rem_out,
  output logic               q_bit
);

  logic [DIVISOR_W:0] shifted;

  assign shifted = {rem_in[DIVISOR_W-1:0], bit_in};
  // A set top bit means the true shifted value exceeds any divisor magnitude.
  assign q_bit   = rem_in[DIVISOR_W] | (shifted >= divisor);
  assign rem_out = q_bit ? (shifted - divisor) : shifted;

endmodule

// File: rtl/div_seq_param.sv
// Multi-cycle radix-2 restoring divider, unsigned or signed (truncating), valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for an operation, in_ready high
//   CALC  | one quotient bit per cycle on operand magnitudes
//   FIX   | apply signs, or load divide-by-zero / overflow results
//   DONE  | result presented until out_ready
module div_seq_param
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_signed,
  input  logic [DIVIDEND_W-1:0] in_dividend,
  input  logic [DIVISOR_W-1:0]  in_divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] out_quotient,
  output logic [DIVISOR_W-1:0]  out_remainder,
  output logic                  out_dbz,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int CNT_W = clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0]      CNT_LAST     = CNT_W'(DIVIDEND_W - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE      = CNT_W'(1);
  localparam logic [DIVIDEND_W-1:0] DIVIDEND_MIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};
  localparam logic [DIVISOR_W-1:0]  DIVISOR_NEG1 = '1;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] quo;
  logic [DIVISOR_W:0]    rem;
  logic [DIVISOR_W:0]    dmag;
  logic                  neg_q;
  logic                  neg_r;

  logic                  a_neg;
  logic                  b_neg;
  logic [DIVIDEND_W-1:0] a_mag;
  logic [DIVISOR_W:0]    b_ext;
  logic [DIVISOR_W:0]    b_mag;
  logic [DIVISOR_W:0]    rem_next;
  logic                  q_bit;

  assign a_neg = in_signed & in_dividend[DIVIDEND_W-1];
  assign b_neg = in_signed & in_divisor[DIVISOR_W-1];
  assign a_mag = a_neg ? -in_dividend : in_dividend;
  // Extra bit keeps the magnitude of the most-negative divisor representable.
  assign b_ext = {b_neg, in_divisor};
  assign b_mag = b_neg ? -b_ext : b_ext;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem_in  (rem),
    .bit_in  (quo[DIVIDEND_W-1]),
    .divisor (dmag),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
      cnt           <= '0;
      quo           <= '0;
      rem           <= '0;
      dmag          <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_dbz       <= 1'b0;
      out_ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            quo      <= a_mag;
            rem      <= '0;
            dmag     <= b_mag;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            out_dbz  <= 1'b0;
            out_ovf  <= 1'b0;
            // Special cases go through FIX so their result lands one edge after accept.
            if (in_divisor == '0) begin
              out_dbz <= 1'b1;
              state   <= FIX;
            end else if (in_signed && in_dividend == DIVIDEND_MIN && in_divisor == DIVISOR_NEG1) begin
              out_ovf <= 1'b1;
              state   <= FIX;
            end else begin
              cnt   <= CNT_LAST;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_next;
          quo <= {quo[DIVIDEND_W-2:0], q_bit};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - CNT_ONE;
        end
        FIX: begin
          if (out_dbz) begin
            out_quotient  <= '1;
            out_remainder <= '0;
          end else if (out_ovf) begin
            out_quotient  <= DIVIDEND_MIN;
            out_remainder <= '0;
          end else begin
            out_quotient  <= neg_q ? -quo : quo;
            out_remainder <= neg_r ? -rem[DIVISOR_W-1:0] : rem[DIVISOR_W-1:0];
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_param.sv
// Scoreboard bench for div_seq_param: directed vectors, backpressure, mid-operation reset, random ops.
module tb_div_seq_param;

  localparam int DW = 16;
  localparam int VW = 8;
  localparam logic [DW-1:0] MIN_A = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] ONES_A = '1;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dbz;
    logic          ovf;
    int            acc;
    int            lat;
  } exp_t;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic          in_signed = 0;
  logic [DW-1:0] in_dividend = '0;
  logic [VW-1:0] in_divisor = '0;
  logic          out_valid;
  logic          out_ready = 1;
  logic [DW-1:0] out_quotient;
  logic [VW-1:0] out_remainder;
  logic          out_dbz;
  logic          out_ovf;
  logic          busy;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   seen = 0;
  bit   rand_bp = 0;
  exp_t exp_q[$];

  div_seq_param #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_signed     (in_signed),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_dbz       (out_dbz),
    .out_ovf       (out_ovf),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [DW-1:0] q, input logic [VW-1:0] r,
                              input logic dbz, input logic ovf);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.acc = 0;
    e.lat = (dbz || ovf) ? 1 : DW + 1;
    return e;
  endfunction

  // Reference: plain integer division, which truncates toward zero with remainder taking the dividend's sign.
  function automatic exp_t model(input logic s, input logic [DW-1:0] a, input logic [VW-1:0] b);
    int sa, sb, qi, ri;
    if (b == '0) return mk(ONES_A, '0, 1'b1, 1'b0);
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    if (s && sa == -(1 << (DW-1)) && sb == -1) return mk(MIN_A, '0, 1'b0, 1'b1);
    qi = sa / sb;
    ri = sa % sb;
    return mk(qi[DW-1:0], ri[VW-1:0], 1'b0, 1'b0);
  endfunction

  task automatic issue(input logic s, input logic [DW-1:0] a, input logic [VW-1:0] b, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1; in_signed = s; in_dividend = a; in_divisor = b;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready stuck at %0b, expected 1", in_ready);
      in_valid = 0;
      return;
    end
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_signed = 1'($urandom);
    in_dividend = DW'($urandom);
    in_divisor = VW'($urandom);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_quotient"}, out_quotient, 0);
    chk({tag, "_remainder"}, out_remainder, 0);
    chk({tag, "_dbz"}, out_dbz, 0);
    chk({tag, "_ovf"}, out_ovf, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: compare the head of the scoreboard when a result first appears and again at handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen = 0;
      exp_q.delete();
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result: out_valid=1 with quotient %0h, expected no result", out_quotient);
      end else begin
        e = exp_q[0];
        if (!seen) begin
          seen = 1;
          chk("latency", cyc - e.acc, e.lat);
          chk("quotient", out_quotient, e.q);
          chk("remainder", out_remainder, e.r);
          chk("dbz", out_dbz, e.dbz);
          chk("ovf", out_ovf, e.ovf);
        end
        if (out_ready) begin
          chk("quotient_at_handshake", out_quotient, e.q);
          chk("remainder_at_handshake", out_remainder, e.r);
          void'(exp_q.pop_front());
          seen = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1 out_ready = 1'($urandom);
    end
  end

  initial begin
    int n;
    bit stale;
    logic s;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    int k;

    #12;
    check_idle("reset");
    @(posedge clk); #1 rst_n = 1;

    issue(0, 16'd1000, 8'd7, mk(16'd142, 8'd6, 0, 0));
    issue(0, 16'hFFFF, 8'd1, mk(16'hFFFF, 8'd0, 0, 0));
    issue(0, 16'd5, 8'd200, mk(16'd0, 8'd5, 0, 0));
    issue(1, 16'hFF9C, 8'h07, mk(16'hFFF2, 8'hFE, 0, 0));
    issue(1, 16'h8000, 8'hFF, mk(16'h8000, 8'h00, 0, 1));
    issue(0, 16'd1234, 8'd0, mk(16'hFFFF, 8'h00, 1, 0));
    drain();

    // Backpressure: result must hold and no new operation may be taken.
    out_ready = 0;
    issue(0, 16'd1000, 8'd7, mk(16'd142, 8'd6, 0, 0));
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", out_valid, 1);
    in_valid = 1; in_signed = 0; in_dividend = 16'd3; in_divisor = 8'd1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_busy", busy, 1);
      chk("bp_hold_quotient", out_quotient, 16'd142);
    end
    in_valid = 0;
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    issue(1, 16'd100, 8'hF9, mk(16'hFFF2, 8'd2, 0, 0));
    issue(1, 16'hFF9C, 8'hF9, mk(16'd14, 8'hFE, 0, 0));
    drain();

    // Reset in the middle of CALC discards the operation.
    issue(0, 16'd1000, 8'd7, mk(16'd142, 8'd6, 0, 0));
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1 check_idle("midreset");
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1;
    stale = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) stale = 1;
    end
    chk("midreset_no_stale_valid", stale, 0);

    // Randomised operations with random output backpressure.
    rand_bp = 1;
    for (int i = 0; i < 150; i++) begin
      s = 1'($urandom);
      a = DW'($urandom);
      b = VW'($urandom);
      k = $urandom_range(0, 15);
      if (k == 0) b = '0;
      if (k == 1) begin s = 1; a = MIN_A; b = '1; end
      if (k == 2) a = MIN_A;
      if (k == 3) b = 8'd1;
      issue(s, a, b, model(s, a, b));
    end
    drain();
    rand_bp = 0;
    @(posedge clk); #1 out_ready = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time exceeded, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
